// File: rtl/pipe_pkg.sv
// Shared constants, ALUOp encodings and reset values for the ID/EX pipeline slice.
package pipe_pkg;

    localparam int XLEN    = 32;
    localparam int REG_AW  = 5;
    localparam int ALUOP_W = 5;

    typedef enum logic [ALUOP_W-1:0] {
        ALU_ADD  = 5'd0,
        ALU_SUB  = 5'd1,
        ALU_AND  = 5'd2,
        ALU_OR   = 5'd3,
        ALU_XOR  = 5'd4,
        ALU_SLL  = 5'd5,
        ALU_SRL  = 5'd6,
        ALU_SRA  = 5'd7,
        ALU_SLT  = 5'd8,
        ALU_SLTU = 5'd9
    } aluOp_e;

    localparam logic [XLEN-1:0]    DATA_RST  = '0;
    localparam logic [REG_AW-1:0]  REG_RST   = '0;
    localparam logic [ALUOP_W-1:0] ALUOP_RST = ALU_ADD;
    localparam logic [31:0]        CNT_RST   = '0;

endpackage

// File: rtl/id_ex_pipe_reg_if.sv
// ID-side inputs and EX-side outputs of the ID/EX register, grouped as one bundle.
interface id_ex_pipe_reg_if;
    import pipe_pkg::*;

    logic                id_valid, id_RegWrite, id_MemtoReg, id_MemWrite;
    logic                id_MemRead, id_Branch, id_ALUSrc;
    logic [ALUOP_W-1:0]  id_ALUOp;
    logic [XLEN-1:0]     id_pc, id_rs1_data, id_rs2_data, id_imm;
    logic [REG_AW-1:0]   id_rs1, id_rs2, id_rd;
    logic [2:0]          id_funct3;

    logic                ex_valid, ex_RegWrite, ex_MemtoReg, ex_MemWrite;
    logic                ex_MemRead, ex_Branch, ex_ALUSrc;
    logic [ALUOP_W-1:0]  ex_ALUOp;
    logic [XLEN-1:0]     ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
    logic [REG_AW-1:0]   ex_rs1, ex_rs2, ex_rd;
    logic [2:0]          ex_funct3;

    logic                ctrl_select, load_use_stall;
    logic [31:0]         bubble_cnt, flush_cnt;

    modport master (
        output id_valid, id_RegWrite, id_MemtoReg, id_MemWrite, id_MemRead,
               id_Branch, id_ALUSrc, id_ALUOp, id_pc, id_rs1_data, id_rs2_data,
               id_imm, id_rs1, id_rs2, id_rd, id_funct3,
        input  ex_valid, ex_RegWrite, ex_MemtoReg, ex_MemWrite, ex_MemRead,
               ex_Branch, ex_ALUSrc, ex_ALUOp, ex_pc, ex_rs1_data, ex_rs2_data,
               ex_imm, ex_rs1, ex_rs2, ex_rd, ex_funct3,
               ctrl_select, load_use_stall, bubble_cnt, flush_cnt
    );

    modport slave (
        input  id_valid, id_RegWrite, id_MemtoReg, id_MemWrite, id_MemRead,
               id_Branch, id_ALUSrc, id_ALUOp, id_pc, id_rs1_data, id_rs2_data,
               id_imm, id_rs1, id_rs2, id_rd, id_funct3,
        output ex_valid, ex_RegWrite, ex_MemtoReg, ex_MemWrite, ex_MemRead,
               ex_Branch, ex_ALUSrc, ex_ALUOp, ex_pc, ex_rs1_data, ex_rs2_data,
               ex_imm, ex_rs1, ex_rs2, ex_rd, ex_funct3,
               ctrl_select, load_use_stall, bubble_cnt, flush_cnt
    );

endinterface

// File: rtl/hazard_detect.sv
// Load-use compare between the load sitting in EX and the sources of the ID instruction.
module hazard_detect
    import pipe_pkg::*;
(
    input  logic              exValid,
    input  logic              exMemRead,
    input  logic [REG_AW-1:0] exRd,
    input  logic              idValid,
    input  logic [REG_AW-1:0] idRs1,
    input  logic [REG_AW-1:0] idRs2,
    input  logic              flush,
    output logic              loadUseStall
);

    // x0 is hardwired zero, so a load targeting it can never feed a consumer
    assign loadUseStall = exValid & exMemRead & (exRd != '0)
                        & ((exRd == idRs1) | (exRd == idRs2))
                        & idValid & ~flush;

endmodule

// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register with hold/flush/load-use bubble priority.
// Define ID_EX_PERF_CNT_EN to build the bubble/flush performance counters.
module id_ex_pipe_reg
    import pipe_pkg::*;
(
    input  logic clk,
    input  logic rstn,
    input  logic hold,
    input  logic flush,
    id_ex_pipe_reg_if.slave pif
);

    logic loadUseStall;

    hazard_detect uHazard (
        .exValid      (pif.ex_valid),
        .exMemRead    (pif.ex_MemRead),
        .exRd         (pif.ex_rd),
        .idValid      (pif.id_valid),
        .idRs1        (pif.id_rs1),
        .idRs2        (pif.id_rs2),
        .flush        (flush),
        .loadUseStall (loadUseStall)
    );

    assign pif.load_use_stall = loadUseStall;
    assign pif.ctrl_select    = ~loadUseStall;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pif.ex_valid    <= 1'b0;
            pif.ex_RegWrite <= 1'b0;
            pif.ex_MemtoReg <= 1'b0;
            pif.ex_MemWrite <= 1'b0;
            pif.ex_MemRead  <= 1'b0;
            pif.ex_Branch   <= 1'b0;
            pif.ex_ALUSrc   <= 1'b0;
            pif.ex_ALUOp    <= ALUOP_RST;
            pif.ex_pc       <= DATA_RST;
            pif.ex_rs1_data <= DATA_RST;
            pif.ex_rs2_data <= DATA_RST;
            pif.ex_imm      <= DATA_RST;
            pif.ex_rs1      <= REG_RST;
            pif.ex_rs2      <= REG_RST;
            pif.ex_rd       <= REG_RST;
            pif.ex_funct3   <= 3'd0;
        end else if (hold) begin
            pif.ex_valid    <= pif.ex_valid;
        end else if (flush) begin
            pif.ex_valid    <= 1'b0;
            pif.ex_RegWrite <= 1'b0;
            pif.ex_MemtoReg <= 1'b0;
            pif.ex_MemWrite <= 1'b0;
            pif.ex_MemRead  <= 1'b0;
            pif.ex_Branch   <= 1'b0;
            pif.ex_ALUSrc   <= 1'b0;
            pif.ex_ALUOp    <= ALUOP_RST;
            pif.ex_pc       <= DATA_RST;
            pif.ex_rs1_data <= DATA_RST;
            pif.ex_rs2_data <= DATA_RST;
            pif.ex_imm      <= DATA_RST;
            pif.ex_rs1      <= REG_RST;
            pif.ex_rs2      <= REG_RST;
            pif.ex_rd       <= REG_RST;
            pif.ex_funct3   <= 3'd0;
        end else begin
            // Controls arrive zeroed from the bubble mux on a stall; gating here
            // keeps the bubble clean even if that mux path ever lags.
            pif.ex_valid    <= pif.id_valid    & ~loadUseStall;
            pif.ex_RegWrite <= pif.id_RegWrite & ~loadUseStall;
            pif.ex_MemtoReg <= pif.id_MemtoReg & ~loadUseStall;
            pif.ex_MemWrite <= pif.id_MemWrite & ~loadUseStall;
            pif.ex_MemRead  <= pif.id_MemRead  & ~loadUseStall;
            pif.ex_Branch   <= pif.id_Branch   & ~loadUseStall;
            pif.ex_ALUSrc   <= pif.id_ALUSrc   & ~loadUseStall;
            pif.ex_ALUOp    <= loadUseStall ? ALUOP_RST : pif.id_ALUOp;
            pif.ex_pc       <= pif.id_pc;
            pif.ex_rs1_data <= pif.id_rs1_data;
            pif.ex_rs2_data <= pif.id_rs2_data;
            pif.ex_imm      <= pif.id_imm;
            pif.ex_rs1      <= pif.id_rs1;
            pif.ex_rs2      <= pif.id_rs2;
            pif.ex_rd       <= pif.id_rd;
            pif.ex_funct3   <= pif.id_funct3;
        end
    end

`ifdef ID_EX_PERF_CNT_EN
    logic [31:0] bubbleCnt;
    logic [31:0] flushCnt;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            bubbleCnt <= CNT_RST;
            flushCnt  <= CNT_RST;
        end else if (!hold) begin
            if (flush)
                flushCnt <= flushCnt + 32'd1;
            else if (loadUseStall)
                bubbleCnt <= bubbleCnt + 32'd1;
        end
    end

    assign pif.bubble_cnt = bubbleCnt;
    assign pif.flush_cnt  = flushCnt;
`else
    assign pif.bubble_cnt = CNT_RST;
    assign pif.flush_cnt  = CNT_RST;
`endif

endmodule
